// File: rtl/rmii_rx_mac.sv
// RMII receive front end: strips preamble/SFD, packs dibits into bytes, holds back
// the 4-byte FCS and reports each frame's status on rx_done/rx_ok.

module crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  logic [31:0] lfsr, lfsr_nxt;

  always_comb begin
    lfsr_nxt = lfsr ^ {24'd0, data};
    for (int i = 0; i < 8; i++)
      lfsr_nxt = lfsr_nxt[0] ? ((lfsr_nxt >> 1) ^ 32'hEDB8_8320) : (lfsr_nxt >> 1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)      lfsr <= '1;
    else if (vld) lfsr <= lfsr_nxt;

  // FCS bytes in wire order: first transmitted byte lands in [31:24]
  assign crc = ~{lfsr[7:0], lfsr[15:8], lfsr[23:16], lfsr[31:24]};
endmodule

module rmii_rx_mac #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eth_crsdv,
  input  logic       eth_rxerr,
  input  logic [1:0] eth_rxd,
  output logic       rx_vld,
  output logic [7:0] rx_dat,
  output logic       rx_sof,
  output logic       rx_done,
  output logic       rx_ok
);

  // state    | meaning
  // IDLE     | waiting for a rising edge of crs_dv
  // PREAMBLE | hunting for the SFD dibit
  // DATA     | packing bytes, emitting through the 4-byte hold-back
  // DROP     | discarding the rest of the carrier
  // CHECK    | one-cycle FCS/length verdict
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, CHECK} state_t;

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [10:0] OVF_L = 11'(MAX_LEN + 1);

  state_t      state, state_nxt;
  logic        crsdv_q, crsdv_d, rxerr_q;
  logic [1:0]  rxd_q;
  logic        seen01, err, pending, sof_pend, crc_clr;
  logic [1:0]  dcnt;
  logic [7:0]  sh;
  logic [10:0] bcnt;
  logic [2:0]  hcnt;
  logic [7:0]  hold [4];
  logic [31:0] crc_code;
  logic        crc_rst;

  logic        rise, byte_done, overflow, emit, sfd, frame_ok;
  logic [7:0]  byte_new;
  logic [10:0] bcnt_inc;

  assign rise      = crsdv_q & ~crsdv_d;
  assign byte_new  = {rxd_q, sh[7:2]};
  assign bcnt_inc  = (bcnt == 11'h7FF) ? bcnt : bcnt + 11'd1;
  assign byte_done = (state == DATA) && crsdv_q && (dcnt == 2'd3);
  assign overflow  = byte_done && (bcnt_inc == OVF_L);
  assign emit      = byte_done && !overflow && (hcnt == 3'd4);
  assign sfd       = (state == PREAMBLE) && (state_nxt == DATA);
  assign frame_ok  = !err && (bcnt >= MIN_L) && (bcnt <= MAX_L) &&
                     ({hold[0], hold[1], hold[2], hold[3]} == crc_code);
  assign crc_rst   = rst | crc_clr;

  crc32 u_crc (
    .clk  (clk),
    .rst  (crc_rst),
    .vld  (emit),
    .data (hold[0]),
    .crc  (crc_code)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rise) state_nxt = PREAMBLE;
      PREAMBLE:
        if (!crsdv_q)
          state_nxt = IDLE;
        else if (rxerr_q || rxd_q == 2'b10 || (rxd_q == 2'b00 && seen01))
          state_nxt = DROP;
        else if (rxd_q == 2'b11)
          state_nxt = DATA;
      DATA:
        if (!crsdv_q)     state_nxt = CHECK;
        else if (overflow) state_nxt = DROP;
      DROP:     if (!crsdv_q) state_nxt = pending ? CHECK : IDLE;
      CHECK:    state_nxt = rise ? PREAMBLE : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // crsdv history resets high so a carrier already present at reset release is not taken as a new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crsdv_q  <= 1'b1;
      crsdv_d  <= 1'b1;
      rxerr_q  <= 1'b0;
      rxd_q    <= 2'b00;
      rx_vld   <= 1'b0;
      rx_dat   <= 8'd0;
      rx_sof   <= 1'b0;
      rx_done  <= 1'b0;
      rx_ok    <= 1'b0;
      seen01   <= 1'b0;
      err      <= 1'b0;
      pending  <= 1'b0;
      sof_pend <= 1'b0;
      crc_clr  <= 1'b1;
      dcnt     <= 2'd0;
      sh       <= 8'd0;
      bcnt     <= 11'd0;
      hcnt     <= 3'd0;
      for (int i = 0; i < 4; i++) hold[i] <= 8'd0;
    end else begin
      crsdv_q <= eth_crsdv;
      crsdv_d <= crsdv_q;
      rxerr_q <= eth_rxerr;
      rxd_q   <= eth_rxd;
      rx_vld  <= emit;
      rx_sof  <= emit & sof_pend;
      if (emit) rx_dat <= hold[0];
      rx_done <= (state == CHECK);
      rx_ok   <= (state == CHECK) && frame_ok;

      if (state != PREAMBLE)
        seen01 <= 1'b0;
      else if (crsdv_q && rxd_q == 2'b01)
        seen01 <= 1'b1;

      if (sfd) begin
        dcnt     <= 2'd0;
        sh       <= 8'd0;
        bcnt     <= 11'd0;
        hcnt     <= 3'd0;
        err      <= 1'b0;
        pending  <= 1'b0;
        sof_pend <= 1'b1;
        crc_clr  <= 1'b1;
        for (int i = 0; i < 4; i++) hold[i] <= 8'd0;
      end else if (state == DATA) begin
        if (crsdv_q) begin
          sh   <= byte_new;
          dcnt <= dcnt + 2'd1;
          if (rxerr_q) err <= 1'b1;
          if (byte_done) begin
            bcnt <= bcnt_inc;
            if (overflow) begin
              err     <= 1'b1;
              pending <= 1'b1;
            end else if (hcnt != 3'd4) begin
              hold[hcnt[1:0]] <= byte_new;
              hcnt            <= hcnt + 3'd1;
              if (hcnt == 3'd3) crc_clr <= 1'b0;
            end else begin
              hold[0]  <= hold[1];
              hold[1]  <= hold[2];
              hold[2]  <= hold[3];
              hold[3]  <= byte_new;
              sof_pend <= 1'b0;
            end
          end
        end else if (dcnt != 2'd0) begin
          err <= 1'b1;
        end
      end else if (state == PREAMBLE && state_nxt == DROP) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rmii_rx_mac.sv
// Directed bench for rmii_rx_mac: table of whole-frame cases plus back-to-back and mid-frame reset.

module tb_rmii_rx_mac;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       eth_crsdv = 1'b0;
  logic       eth_rxerr = 1'b0;
  logic [1:0] eth_rxd = 2'b00;
  logic       rx_vld, rx_sof, rx_done, rx_ok;
  logic [7:0] rx_dat;

  rmii_rx_mac #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk       (clk),
    .rst       (rst),
    .eth_crsdv (eth_crsdv),
    .eth_rxerr (eth_rxerr),
    .eth_rxd   (eth_rxd),
    .rx_vld    (rx_vld),
    .rx_dat    (rx_dat),
    .rx_sof    (rx_sof),
    .rx_done   (rx_done),
    .rx_ok     (rx_ok)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_end    = 0;
  int done_cyc = -100;
  int done_cnt = 0;
  int both_cnt = 0;
  int stray_ok = 0;
  logic [7:0] got_q [$];
  logic       sof_q [$];
  logic       ok_q  [$];

  typedef struct {
    int len;
    bit bad_fcs;
    int err_byte;
    int extra;
    bit bad_pre;
    int exp_bytes;
    bit exp_done;
    bit exp_ok;
  } vec_t;

  vec_t  vecs [9];
  string names [9];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_vld) begin
      got_q.push_back(rx_dat);
      sof_q.push_back(rx_sof);
    end
    if (rx_done) begin
      done_cnt++;
      ok_q.push_back(rx_ok);
      done_cyc = cyc;
    end
    if (rx_vld && rx_done) both_cnt++;
    if (rx_ok && !rx_done) stray_ok++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [7:0] q [$]);
    logic [31:0] c;
    logic        fb;
    c = '1;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  task automatic dibit(input logic [1:0] d, input logic crs, input logic er);
    @(negedge clk);
    eth_rxd   = d;
    eth_crsdv = crs;
    eth_rxerr = er;
  endtask

  task automatic clear_mon();
    got_q    = {};
    sof_q    = {};
    ok_q     = {};
    done_cnt = 0;
    done_cyc = -100;
  endtask

  task automatic send_frame(input int len, input bit bad_fcs, input int err_byte,
                            input int extra, input bit bad_pre, input int rst_byte);
    logic [7:0]  fr [$];
    logic [31:0] fcs;
    logic [7:0]  b;
    int          npay;
    fr   = {};
    npay = (len >= 4) ? len - 4 : len;
    for (int i = 0; i < npay; i++) fr.push_back(8'(i));
    if (len >= 4) begin
      fcs = crc_model(fr);
      fr.push_back(fcs[7:0] ^ {7'd0, bad_fcs});
      fr.push_back(fcs[15:8]);
      fr.push_back(fcs[23:16]);
      fr.push_back(fcs[31:24]);
    end
    for (int p = 0; p < 32; p++)
      dibit((bad_pre && p == 10) ? 2'b10 : ((p == 31) ? 2'b11 : 2'b01), 1'b1, 1'b0);
    foreach (fr[i]) begin
      b = fr[i];
      for (int d = 0; d < 4; d++) begin
        dibit(b[2*d +: 2], 1'b1, (i == err_byte && d == 0));
        if (rst_byte >= 0 && i == rst_byte && d == 1) begin
          check("vld before reset", int'(rx_vld), 1);
          check("dat before reset", int'(rx_dat), rst_byte - 5);
          rst = 1'b1;
          #1;
          check("vld in reset", int'(rx_vld), 0);
          check("dat in reset", int'(rx_dat), 0);
          check("sof in reset", int'(rx_sof), 0);
        end
        if (rst_byte >= 0 && i == rst_byte + 2 && d == 0) rst = 1'b0;
      end
    end
    for (int e = 0; e < extra; e++) dibit(2'b10, 1'b1, 1'b0);
    dibit(2'b00, 1'b0, 1'b0);
    t_end = cyc;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_cnt < n && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_stream(input string nm, input int exp_bytes, input int per);
    int bad;
    int sbad;
    bad  = 0;
    sbad = 0;
    check({nm, " bytes"}, got_q.size(), exp_bytes);
    for (int k = 0; k < got_q.size(); k++) begin
      if (got_q[k] != 8'(k % per)) bad++;
      if (sof_q[k] != ((k % per) == 0)) sbad++;
    end
    check({nm, " data"}, bad, 0);
    check({nm, " sof"}, sbad, 0);
  endtask

  initial begin
    vecs[0] = '{64,   0, -1, 0, 0, 60,   1, 1};  names[0] = "good";
    vecs[1] = '{64,   1, -1, 0, 0, 60,   1, 0};  names[1] = "bad_fcs";
    vecs[2] = '{64,   0, 10, 0, 0, 60,   1, 0};  names[2] = "phy_err";
    vecs[3] = '{20,   0, -1, 0, 0, 16,   1, 0};  names[3] = "runt";
    vecs[4] = '{1518, 0, -1, 0, 0, 1514, 1, 1};  names[4] = "max_len";
    vecs[5] = '{1519, 0, -1, 0, 0, 1514, 1, 0};  names[5] = "over_len";
    vecs[6] = '{64,   0, -1, 2, 0, 60,   1, 0};  names[6] = "partial";
    vecs[7] = '{64,   0, -1, 0, 1, 0,    0, 0};  names[7] = "bad_pre";
    vecs[8] = '{3,    0, -1, 0, 0, 0,    1, 0};  names[8] = "tiny";

    repeat (3) @(negedge clk);
    check("reset vld",  int'(rx_vld),  0);
    check("reset dat",  int'(rx_dat),  0);
    check("reset sof",  int'(rx_sof),  0);
    check("reset done", int'(rx_done), 0);
    check("reset ok",   int'(rx_ok),   0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      clear_mon();
      send_frame(vecs[v].len, vecs[v].bad_fcs, vecs[v].err_byte, vecs[v].extra, vecs[v].bad_pre, -1);
      wait_done(1);
      check_stream(names[v], vecs[v].exp_bytes, (vecs[v].len >= 4) ? vecs[v].len - 4 : vecs[v].len);
      check({names[v], " done count"}, done_cnt, int'(vecs[v].exp_done));
      if (vecs[v].exp_done) begin
        check({names[v], " ok"}, (ok_q.size() > 0) ? int'(ok_q[0]) : -1, int'(vecs[v].exp_ok));
        check({names[v], " done latency"}, done_cyc - t_end, 3);
      end
    end

    clear_mon();
    send_frame(64, 0, -1, 0, 0, -1);
    send_frame(64, 0, -1, 0, 0, -1);
    wait_done(2);
    check_stream("b2b", 120, 60);
    check("b2b done count", done_cnt, 2);
    check("b2b ok0", (ok_q.size() > 0) ? int'(ok_q[0]) : -1, 1);
    check("b2b ok1", (ok_q.size() > 1) ? int'(ok_q[1]) : -1, 1);
    check("b2b done latency", done_cyc - t_end, 3);

    clear_mon();
    send_frame(64, 0, -1, 0, 0, 20);
    repeat (60) @(negedge clk);
    check_stream("rst_mid", 16, 60);
    check("rst_mid done count", done_cnt, 0);

    clear_mon();
    send_frame(64, 0, -1, 0, 0, -1);
    wait_done(1);
    check_stream("after_rst", 60, 60);
    check("after_rst done count", done_cnt, 1);
    check("after_rst ok", (ok_q.size() > 0) ? int'(ok_q[0]) : -1, 1);

    check("vld with done", both_cnt, 0);
    check("ok without done", stray_ok, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
